// File: rtl/qfx_pkg.sv
// qfx_pkg: op-field positions, FSM states and signed range helpers shared by the qfx blocks
package qfx_pkg;
  localparam int OP_DIV = 2;
  localparam int OP_NEG_A = 1;
  localparam int OP_NEG_C = 0;
  localparam int MAX_W = 256;
  typedef enum logic [1:0] {IDLE, MAD, DIV, DONE} state_t;
  function automatic logic [MAX_W-1:0] max_val(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction
  function automatic logic [MAX_W-1:0] min_val(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/qfx_if.sv
// qfx_if: request/response bundle between a qfx_unit and its client
interface qfx_if #(parameter int WIDTH = 64);
  logic in_valid;
  logic in_ready;
  logic [2:0] op;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] c_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] res;
  logic ovf;
  logic div0;
  logic busy;
  modport master(output in_valid, op, a_data, b_data, c_data, out_ready,
                 input in_ready, out_valid, res, ovf, div0, busy);
  modport slave(input in_valid, op, a_data, b_data, c_data, out_ready,
                output in_ready, out_valid, res, ovf, div0, busy);
endinterface

// File: rtl/qfx_divider.sv
// qfx_divider: restoring radix-2 divider on magnitudes, one quotient bit per cycle over WIDTH+FRAC cycles
module qfx_divider #(
  parameter int WIDTH = 64,
  parameter int FRAC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dvs,
  output logic o_busy,
  output logic o_done,
  output logic o_ovf,
  output logic [WIDTH+FRAC-1:0] o_quo
);
  localparam int N = WIDTH + FRAC;
  localparam int CW = $clog2(N);
  logic [N-1:0] r_dvd, r_quo;
  logic [WIDTH-1:0] r_dvs, r_rem;
  logic [CW-1:0] r_cnt;
  logic r_busy;
  logic [WIDTH:0] w_trial;
  logic [WIDTH-1:0] w_diff;
  logic w_ge;
  // remainder stays below the divisor, so the trial value needs only one extra bit
  assign w_trial = {r_rem, r_dvd[N-1]};
  assign w_ge = w_trial >= {1'b0, r_dvs};
  assign w_diff = w_ge ? WIDTH'(w_trial - {1'b0, r_dvs}) : w_trial[WIDTH-1:0];
  assign o_quo = {r_quo[N-2:0], w_ge};
  assign o_done = r_busy && r_cnt == CW'(N - 1);
  assign o_busy = r_busy;
  assign o_ovf = |o_quo[N-1:WIDTH-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_dvd <= {i_dvd, {FRAC{1'b0}}};
      r_dvs <= i_dvs;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_dvd <= r_dvd << 1;
      r_rem <= w_diff;
      r_quo <= o_quo;
      r_cnt <= r_cnt + CW'(1);
      r_busy <= !o_done;
    end
endmodule

// File: rtl/qfx_unit.sv
// qfx_unit: signed fixed-point multiply-add / divide unit, saturating or wrapping on overflow
module qfx_unit import qfx_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int FRAC = 15,
  parameter bit SAT = 1'b1
) (
  input logic clk,
  input logic reset,
  qfx_if.slave bus
);
  localparam int N = WIDTH + FRAC;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] MINV = WIDTH'(min_val(WIDTH));
  localparam logic [N-1:0] MIN_MAG = N'(min_val(WIDTH));
  state_t r_state;
  logic [WIDTH:0] r_a, r_c;
  logic [WIDTH-1:0] r_b, r_res;
  logic r_neg, r_out_valid, r_ovf, r_div0;
  logic [WIDTH:0] w_ap, w_cp;
  logic [WIDTH-1:0] w_am, w_bm, w_mres, w_dres;
  logic w_dv_start, w_dv_busy, w_dv_done, w_dv_ovf, w_mov, w_dov;
  logic [N-1:0] w_q;
  logic signed [2*WIDTH:0] w_prod, w_sh;
  logic [2*WIDTH+1:0] w_sum;
  // one extra bit so negating the most-negative operand does not wrap
  assign w_ap = bus.op[OP_NEG_A] ? -{bus.a_data[WIDTH-1], bus.a_data} : {bus.a_data[WIDTH-1], bus.a_data};
  assign w_cp = bus.op[OP_NEG_C] ? -{bus.c_data[WIDTH-1], bus.c_data} : {bus.c_data[WIDTH-1], bus.c_data};
  assign w_am = w_ap[WIDTH] ? WIDTH'(-w_ap) : w_ap[WIDTH-1:0];
  assign w_bm = bus.b_data[WIDTH-1] ? -bus.b_data : bus.b_data;
  assign w_dv_start = bus.in_valid && r_state == IDLE && bus.op[OP_DIV] && |bus.b_data;
  assign w_prod = {{WIDTH{r_a[WIDTH]}}, r_a} * {{(WIDTH+1){r_b[WIDTH-1]}}, r_b};
  assign w_sh = w_prod >>> FRAC;
  assign w_sum = {w_sh[2*WIDTH], w_sh} + {{(WIDTH+1){r_c[WIDTH]}}, r_c};
  assign w_mov = !(&w_sum[2*WIDTH+1:WIDTH-1]) && |w_sum[2*WIDTH+1:WIDTH-1];
  assign w_mres = (SAT && w_mov) ? (w_sum[2*WIDTH+1] ? MINV : MAXV) : w_sum[WIDTH-1:0];
  // a negative quotient may reach magnitude 2^(WIDTH-1) without overflowing
  assign w_dov = w_dv_ovf && !(r_neg && w_q == MIN_MAG);
  assign w_dres = (SAT && w_dov) ? (r_neg ? MINV : MAXV) : (r_neg ? WIDTH'(-w_q) : w_q[WIDTH-1:0]);
  qfx_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) u_div (
    .clk(clk),
    .reset(reset),
    .i_start(w_dv_start),
    .i_dvd(w_am),
    .i_dvs(w_bm),
    .o_busy(w_dv_busy),
    .o_done(w_dv_done),
    .o_ovf(w_dv_ovf),
    .o_quo(w_q)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_neg <= 1'b0;
      r_res <= '0;
      r_ovf <= 1'b0;
      r_div0 <= 1'b0;
      r_out_valid <= 1'b0;
    end else
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a <= w_ap;
          r_b <= bus.b_data;
          r_c <= w_cp;
          r_neg <= w_ap[WIDTH] ^ bus.b_data[WIDTH-1];
          if (!bus.op[OP_DIV]) r_state <= MAD;
          else if (|bus.b_data) r_state <= DIV;
          else begin
            r_state <= DONE;
            r_out_valid <= 1'b1;
            r_div0 <= 1'b1;
            r_res <= w_ap[WIDTH] ? MINV : MAXV;
          end
        end
        MAD: begin
          r_state <= DONE;
          r_out_valid <= 1'b1;
          r_res <= w_mres;
          r_ovf <= w_mov;
        end
        DIV: if (w_dv_done) begin
          r_state <= DONE;
          r_out_valid <= 1'b1;
          r_res <= w_dres;
          r_ovf <= w_dov;
        end
        DONE: if (bus.out_ready) begin
          r_state <= IDLE;
          r_out_valid <= 1'b0;
          r_ovf <= 1'b0;
          r_div0 <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
  assign bus.in_ready = r_state == IDLE;
  assign bus.busy = r_state != IDLE || w_dv_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.res = r_res;
  assign bus.ovf = r_ovf;
  assign bus.div0 = r_div0;
endmodule

// File: tb/tb_qfx_unit.sv
// tb_qfx_unit: randomized and directed checks of saturating and wrapping qfx_unit instances against an arbitrary-precision model
module tb_qfx_unit;
  localparam int W = 64;
  localparam int F = 15;
  localparam logic signed [255:0] MX = (256'sd1 <<< (W - 1)) - 256'sd1;
  localparam logic signed [255:0] MN = -(256'sd1 <<< (W - 1));
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [W-1:0] last_s, last_w;
  always #5 clk = ~clk;
  qfx_if #(.WIDTH(W)) bs();
  qfx_if #(.WIDTH(W)) bw();
  assign bw.in_valid = bs.in_valid;
  assign bw.op = bs.op;
  assign bw.a_data = bs.a_data;
  assign bw.b_data = bs.b_data;
  assign bw.c_data = bs.c_data;
  assign bw.out_ready = bs.out_ready;
  qfx_unit #(.WIDTH(W), .FRAC(F), .SAT(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bs.slave));
  qfx_unit #(.WIDTH(W), .FRAC(F), .SAT(1'b0)) dut_w (.clk(clk), .reset(reset), .bus(bw.slave));

  function automatic void model(input logic [2:0] op, input logic signed [W-1:0] a, b, c, input bit sat,
                                output logic [W-1:0] r, output logic ov, output logic dz, output int lat);
    logic signed [255:0] ap, cp, v;
    ap = a;
    cp = c;
    if (op[1]) ap = -ap;
    if (op[0]) cp = -cp;
    dz = 1'b0;
    ov = 1'b0;
    if (!op[2]) begin
      v = ((ap * b) >>> F) + cp;
      lat = 2;
    end else if (b == 0) begin
      dz = 1'b1;
      lat = 1;
      v = (ap < 0) ? MN : MX;
    end else begin
      v = (ap <<< F) / b;
      lat = W + F + 1;
    end
    if (v > MX || v < MN) begin
      ov = 1'b1;
      if (sat) v = (v > MX) ? MX : MN;
    end
    r = v[W-1:0];
  endfunction

  task automatic scramble();
    bs.in_valid = 1'($urandom_range(0, 1));
    bs.op = 3'($urandom);
    bs.a_data = {$urandom, $urandom};
    bs.b_data = {$urandom, $urandom};
    bs.c_data = {$urandom, $urandom};
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a, b, c, input int stall);
    logic [W-1:0] rs, rw;
    logic os, ow, dz;
    int el, lat;
    model(op, a, b, c, 1'b1, rs, os, dz, el);
    model(op, a, b, c, 1'b0, rw, ow, dz, el);
    @(negedge clk);
    checks++;
    if (bs.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s in_ready_idle: got %b want 1", nm, bs.in_ready);
    end
    bs.in_valid = 1'b1;
    bs.op = op;
    bs.a_data = a;
    bs.b_data = b;
    bs.c_data = c;
    @(negedge clk);
    bs.in_valid = 1'b0;
    lat = 1;
    while (bs.out_valid !== 1'b1 && lat < 200) begin
      scramble();
      @(negedge clk);
      lat++;
    end
    bs.in_valid = 1'b0;
    checks++;
    if (lat !== el) begin
      errs++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
    end
    checks++;
    if (bs.res !== rs || bs.ovf !== os || bs.div0 !== dz) begin
      errs++;
      $display("FAIL %s sat_result: got res=%0d ovf=%b div0=%b want res=%0d ovf=%b div0=%b",
               nm, $signed(bs.res), bs.ovf, bs.div0, $signed(rs), os, dz);
    end
    checks++;
    if (bw.res !== rw || bw.ovf !== ow || bw.div0 !== dz) begin
      errs++;
      $display("FAIL %s wrap_result: got res=%0d ovf=%b div0=%b want res=%0d ovf=%b div0=%b",
               nm, $signed(bw.res), bw.ovf, bw.div0, $signed(rw), ow, dz);
    end
    last_s = bs.res;
    last_w = bw.res;
    for (int i = 0; i < stall; i++) begin
      scramble();
      @(negedge clk);
      checks++;
      if (bs.out_valid !== 1'b1 || bs.in_ready !== 1'b0 || bs.busy !== 1'b1 || bs.res !== rs || bs.ovf !== os || bw.res !== rw) begin
        errs++;
        $display("FAIL %s stall_hold: got v=%b rdy=%b busy=%b res=%0d want v=1 rdy=0 busy=1 res=%0d",
                 nm, bs.out_valid, bs.in_ready, bs.busy, $signed(bs.res), $signed(rs));
      end
    end
    bs.in_valid = 1'b0;
    bs.out_ready = 1'b1;
    @(negedge clk);
    bs.out_ready = 1'b0;
    checks++;
    if (bs.out_valid !== 1'b0 || bs.ovf !== 1'b0 || bs.div0 !== 1'b0 || bs.in_ready !== 1'b1 || bw.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL %s release: got v=%b ovf=%b div0=%b rdy=%b want v=0 ovf=0 div0=0 rdy=1",
               nm, bs.out_valid, bs.ovf, bs.div0, bs.in_ready);
    end
  endtask

  task automatic test_reset();
    bs.in_valid = 1'b0;
    bs.out_ready = 1'b0;
    bs.op = '0;
    bs.a_data = '0;
    bs.b_data = '0;
    bs.c_data = '0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bs.out_valid !== 1'b0 || bs.busy !== 1'b0 || bs.res !== '0 || bs.ovf !== 1'b0 || bs.div0 !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: got v=%b busy=%b res=%0d ovf=%b div0=%b want all 0",
               bs.out_valid, bs.busy, bs.res, bs.ovf, bs.div0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bs.in_ready !== 1'b1 || bw.in_ready !== 1'b1 || bw.res !== '0 || bw.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got rdy=%b/%b res=%0d want rdy=1/1 res=0", bs.in_ready, bw.in_ready, bw.res);
    end
  endtask

  task automatic test_directed();
    run_op("mad_basic", 3'b000, 64'd65536, 64'd98304, 64'd16384, 0);
    checks++;
    if (last_s !== 64'd212992) begin errs++; $display("FAIL mad_basic_value: got %0d want 212992", $signed(last_s)); end
    run_op("mad_neg", 3'b011, 64'd65536, 64'd98304, 64'd16384, 0);
    checks++;
    if (last_s !== -64'sd212992) begin errs++; $display("FAIL mad_neg_value: got %0d want -212992", $signed(last_s)); end
    run_op("div_basic", 3'b100, 64'd32768, 64'd98304, 64'd0, 0);
    checks++;
    if (last_s !== 64'd10922) begin errs++; $display("FAIL div_basic_value: got %0d want 10922", $signed(last_s)); end
    run_op("div_neg", 3'b110, 64'd32768, 64'd98304, 64'd0, 0);
    checks++;
    if (last_s !== -64'sd10922) begin errs++; $display("FAIL div_neg_value: got %0d want -10922", $signed(last_s)); end
    run_op("div_zero", 3'b100, -64'sd5, 64'd0, 64'd0, 0);
    checks++;
    if (last_s !== 64'h8000_0000_0000_0000) begin errs++; $display("FAIL div_zero_value: got %h want 8000000000000000", last_s); end
    run_op("mad_ovf", 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd65536, 64'd0, 0);
    checks++;
    if (last_s !== 64'h7FFF_FFFF_FFFF_FFFF || last_w !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errs++;
      $display("FAIL mad_ovf_value: got sat=%h wrap=%h want 7fffffffffffffff fffffffffffffffe", last_s, last_w);
    end
    run_op("neg_min", 3'b010, 64'h8000_0000_0000_0000, 64'd32768, 64'd0, 0);
    run_op("div_to_min", 3'b100, -(64'sd1 <<< 48), 64'd1, 64'd0, 0);
    run_op("div_past_max", 3'b101, 64'sd1 <<< 48, 64'd1, 64'd5, 0);
    run_op("stall", 3'b001, 64'd98304, -64'sd40000, 64'd777, 5);
  endtask

  function automatic logic [W-1:0] pick(input int k);
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    if (k == 1) begin
      v = W'($urandom_range(0, 1 << 22));
      if ($urandom_range(0, 1) == 1) v = -v;
    end else if (k == 2) begin
      case ($urandom_range(0, 4))
        0: v = 64'h8000_0000_0000_0000;
        1: v = 64'h7FFF_FFFF_FFFF_FFFF;
        2: v = '0;
        3: v = '1;
        default: v = 64'd1;
      endcase
    end
    return v;
  endfunction

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] a, b, c;
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom);
      a = pick($urandom_range(0, 2));
      b = pick($urandom_range(0, 2));
      c = pick($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) b = '0;
      run_op("random", op, a, b, c, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    @(negedge clk);
    bs.in_valid = 1'b1;
    bs.op = 3'b100;
    bs.a_data = 64'd123456789;
    bs.b_data = 64'd3;
    @(negedge clk);
    bs.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bs.out_valid !== 1'b0 || bs.busy !== 1'b0 || bw.busy !== 1'b0 || bs.res !== '0 || bs.ovf !== 1'b0) begin
      errs++;
      $display("FAIL mid_div_reset: got v=%b busy=%b/%b res=%0d want v=0 busy=0/0 res=0",
               bs.out_valid, bs.busy, bw.busy, bs.res);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bs.in_ready !== 1'b1) begin errs++; $display("FAIL mid_div_ready: got %b want 1", bs.in_ready); end
    seen = 0;
    repeat (90) begin
      @(negedge clk);
      if (bs.out_valid === 1'b1 || bw.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errs++; $display("FAIL mid_div_ghost: got %0d out_valid cycles want 0", seen); end
    run_op("after_reset", 3'b000, 64'd65536, 64'd98304, 64'd16384, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] er;
    logic eo, ed;
    int el, t;
    model(3'b000, 64'd65536, -64'sd49152, 64'd100, 1'b1, er, eo, ed, el);
    @(negedge clk);
    bs.op = 3'b000;
    bs.a_data = 64'd65536;
    bs.b_data = -64'sd49152;
    bs.c_data = 64'd100;
    bs.in_valid = 1'b1;
    bs.out_ready = 1'b1;
    t = 0;
    while (bs.out_valid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 10) begin errs++; $display("FAIL b2b_first: got no out_valid within %0d cycles want out_valid", t); end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 9) bs.in_valid = 1'b0;
      checks++;
      if (bs.out_valid !== (j % 3 == 0) || (bs.out_valid === 1'b1 && bs.res !== er)) begin
        errs++;
        $display("FAIL b2b_cycle%0d: got v=%b res=%0d want v=%b res=%0d", j, bs.out_valid, $signed(bs.res), j % 3 == 0, $signed(er));
      end
    end
    @(negedge clk);
    bs.out_ready = 1'b0;
    checks++;
    if (bs.in_ready !== 1'b1 || bs.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: got rdy=%b v=%b want rdy=1 v=0", bs.in_ready, bs.out_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
